// File: rtl/seg7_scan_ctrl_if.sv
// CPU-side register bus for the seven-segment scan controller.
// The CPU (master) writes VALUE/CTRL and reads back registered data.
`timescale 1ns/1ps
interface seg7_scan_ctrl_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller with a double-buffered display value,
// a blanking gap after every digit slot and a CPU-visible frame counter.
`timescale 1ns/1ps
module seg7_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int FRAME_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    seg7_scan_ctrl_if.slave  bus,
    output logic [6:0]       segments,
    output logic             decimal_point,
    output logic [3:0]       anode,
    output logic             frame_tick
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [15:0]      CTRL_MASK  = 16'h0FF1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t             r_state, w_nextState;
    logic [15:0]        r_value, w_value;
    logic [15:0]        r_ctrl, w_ctrl;
    logic [15:0]        r_shadow, w_shadow;
    logic [1:0]         r_digit, w_digit;
    logic [CNT_W-1:0]   r_phase, w_phase;
    logic [FRAME_W-1:0] r_frame, w_frame;
    logic               r_tick, w_tick;
    logic [6:0]         r_segments, w_segments;
    logic               r_dp, w_dp;
    logic [3:0]         r_anode, w_anode;
    logic [15:0]        r_rdData, w_rdData;
    logic [15:0]        w_status;
    logic [3:0]         w_digMask, w_dpMask;

    function automatic logic [6:0] hexDecode(input logic [3:0] nibble);
        case (nibble)
            4'h0: hexDecode = 7'h40;
            4'h1: hexDecode = 7'h79;
            4'h2: hexDecode = 7'h24;
            4'h3: hexDecode = 7'h30;
            4'h4: hexDecode = 7'h19;
            4'h5: hexDecode = 7'h12;
            4'h6: hexDecode = 7'h02;
            4'h7: hexDecode = 7'h78;
            4'h8: hexDecode = 7'h00;
            4'h9: hexDecode = 7'h10;
            4'hA: hexDecode = 7'h08;
            4'hB: hexDecode = 7'h03;
            4'hC: hexDecode = 7'h46;
            4'hD: hexDecode = 7'h21;
            4'hE: hexDecode = 7'h06;
            default: hexDecode = 7'h0E;
        endcase
    endfunction

    // Control decisions use the post-write CTRL so enable and mask changes act on this edge.
    always_comb begin
        w_value = r_value;
        w_ctrl  = r_ctrl;
        if (bus.wr_en && bus.wr_addr == 2'd0) w_value = bus.wr_data;
        if (bus.wr_en && bus.wr_addr == 2'd1) w_ctrl  = bus.wr_data & CTRL_MASK;
    end

    always_comb begin
        w_nextState = r_state;
        w_digit     = r_digit;
        w_phase     = r_phase;
        w_shadow    = r_shadow;
        w_frame     = r_frame;
        w_tick      = 1'b0;
        if (!w_ctrl[0]) begin
            w_nextState = S_IDLE;
            w_digit     = 2'd0;
            w_phase     = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nextState = S_DRIVE;
                    w_shadow    = r_value;
                    w_digit     = 2'd0;
                    w_phase     = '0;
                end
                S_DRIVE: begin
                    if (r_phase == DRIVE_LAST) begin
                        w_nextState = S_BLANK;
                        w_phase     = '0;
                    end else begin
                        w_phase = r_phase + CNT_W'(1);
                    end
                end
                S_BLANK: begin
                    if (r_phase == BLANK_LAST) begin
                        w_nextState = S_DRIVE;
                        w_phase     = '0;
                        if (r_digit == 2'd3) begin
                            w_digit  = 2'd0;
                            w_shadow = r_value;
                            w_frame  = r_frame + FRAME_W'(1);
                            w_tick   = 1'b1;
                        end else begin
                            w_digit = r_digit + 2'd1;
                        end
                    end else begin
                        w_phase = r_phase + CNT_W'(1);
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                    w_digit     = 2'd0;
                    w_phase     = '0;
                end
            endcase
        end
    end

    // Outputs are precomputed from the next state so the registered pins line up with it.
    always_comb begin
        w_digMask  = w_ctrl[11:8];
        w_dpMask   = w_ctrl[7:4];
        w_anode    = 4'hF;
        w_segments = 7'h7F;
        w_dp       = 1'b1;
        if (w_nextState == S_DRIVE) begin
            w_segments = hexDecode(w_shadow[{w_digit, 2'b00} +: 4]);
            if (w_digMask[w_digit]) begin
                w_anode = ~(4'b0001 << w_digit);
                w_dp    = ~w_dpMask[w_digit];
            end
        end
    end

    always_comb begin
        w_status       = '0;
        w_status[1:0]  = r_digit;
        w_status[2]    = r_ctrl[0] && (r_state != S_IDLE);
        w_status[15:8] = 8'(r_frame);
        case (bus.rd_addr)
            2'd0:    w_rdData = r_value;
            2'd1:    w_rdData = r_ctrl;
            2'd2:    w_rdData = w_status;
            default: w_rdData = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_value    <= '0;
            r_ctrl     <= '0;
            r_shadow   <= '0;
            r_digit    <= '0;
            r_phase    <= '0;
            r_frame    <= '0;
            r_tick     <= 1'b0;
            r_segments <= 7'h7F;
            r_dp       <= 1'b1;
            r_anode    <= 4'hF;
            r_rdData   <= '0;
        end else begin
            r_state    <= w_nextState;
            r_value    <= w_value;
            r_ctrl     <= w_ctrl;
            r_shadow   <= w_shadow;
            r_digit    <= w_digit;
            r_phase    <= w_phase;
            r_frame    <= w_frame;
            r_tick     <= w_tick;
            r_segments <= w_segments;
            r_dp       <= w_dp;
            r_anode    <= w_anode;
            r_rdData   <= w_rdData;
        end
    end

    assign segments      = r_segments;
    assign decimal_point = r_dp;
    assign anode         = r_anode;
    assign frame_tick    = r_tick;
    assign bus.rd_data   = r_rdData;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a time-based display model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

    localparam int CLK_DIV      = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int SLOT         = CLK_DIV + BLANK_CYCLES;
    localparam int FRAME        = 4 * SLOT;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [6:0] segments;
    logic       decimal_point;
    logic [3:0] anode;
    logic       frame_tick;

    seg7_scan_ctrl_if bus();

    seg7_scan_ctrl #(
        .CLK_DIV(CLK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .FRAME_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .segments(segments),
        .decimal_point(decimal_point),
        .anode(anode),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int c0 = 0;
    bit cmpOn = 1'b0;

    always @(posedge clk) cyc++;

    // Reference model: display content follows from time elapsed since enable.
    logic [6:0]  hexTbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] mVal = '0, mCtrl = '0, mShadow = '0, mValNext, mCtrlNext;
    logic [7:0]  mFrame = '0;
    bit          mRun = 1'b0;
    int          mT = 0;
    int          mDig;
    logic [6:0]  eSeg = 7'h7F;
    logic        eDp = 1'b1;
    logic [3:0]  eAn = 4'hF;
    logic        eTick = 1'b0;
    logic [15:0] eRd = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mVal = '0; mCtrl = '0; mShadow = '0; mFrame = '0; mRun = 1'b0; mT = 0;
            eSeg = 7'h7F; eDp = 1'b1; eAn = 4'hF; eTick = 1'b0; eRd = '0;
        end else begin
            mDig = mRun ? (mT % FRAME) / SLOT : 0;
            case (bus.rd_addr)
                2'd0:    eRd = mVal;
                2'd1:    eRd = mCtrl;
                2'd2:    eRd = {mFrame, 5'b0, (mCtrl[0] && mRun), 2'(mDig)};
                default: eRd = 16'h0000;
            endcase
            mValNext  = (bus.wr_en && bus.wr_addr == 2'd0) ? bus.wr_data : mVal;
            mCtrlNext = (bus.wr_en && bus.wr_addr == 2'd1) ? (bus.wr_data & 16'h0FF1) : mCtrl;
            eTick = 1'b0;
            if (!mCtrlNext[0]) begin
                mRun = 1'b0;
            end else if (!mRun) begin
                mRun = 1'b1;
                mT = 0;
                mShadow = mVal;
            end else begin
                mT++;
                if (mT % FRAME == 0) begin
                    mShadow = mVal;
                    mFrame++;
                    eTick = 1'b1;
                end
            end
            mVal = mValNext;
            mCtrl = mCtrlNext;
            eAn = 4'hF; eSeg = 7'h7F; eDp = 1'b1;
            if (mRun && (mT % SLOT) < CLK_DIV) begin
                mDig = (mT % FRAME) / SLOT;
                eSeg = hexTbl[(mShadow >> (4 * mDig)) & 16'hF];
                if (mCtrl[8 + mDig]) begin
                    eAn = ~(4'b0001 << mDig);
                    eDp = ~mCtrl[4 + mDig];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkDisplay(input string name, input logic [3:0] an, input logic [6:0] seg);
        checkOutput({name, "_anode"}, 32'(anode), 32'(an));
        checkOutput({name, "_seg"}, 32'(segments), 32'(seg));
    endtask

    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("mdl_anode", 32'(anode), 32'(eAn));
            checkOutput("mdl_seg", 32'(segments), 32'(eSeg));
            checkOutput("mdl_dp", 32'(decimal_point), 32'(eDp));
            checkOutput("mdl_tick", 32'(frame_tick), 32'(eTick));
            checkOutput("mdl_rd", 32'(bus.rd_data), 32'(eRd));
        end
    end

    // Drive one bus cycle from a falling edge; the rising edge in between samples it.
    task automatic applyStimulus(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                                 input logic [1:0] ra);
        bus.wr_en = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_addr = ra;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic waitTo(input int k);
        while (cyc < c0 + k) @(negedge clk);
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 16'h0000;
        bus.rd_addr = 2'd0;
        repeat (3) @(negedge clk);
        checkDisplay("rst", 4'hF, 7'h7F);
        checkOutput("rst_dp", 32'(decimal_point), 32'd1);
        checkOutput("rst_tick", 32'(frame_tick), 32'd0);
        checkOutput("rst_rd", 32'(bus.rd_data), 32'd0);
        reset_n = 1'b1;
        cmpOn = 1'b1;
        @(negedge clk);

        // Basic scan of 1234 with all digits enabled
        applyStimulus(1'b1, 2'd0, 16'h1234, 2'd0);
        applyStimulus(1'b1, 2'd1, 16'h0F01, 2'd0);
        c0 = cyc;
        checkDisplay("d0", 4'b1110, 7'h19);
        waitTo(4);  checkDisplay("blank0", 4'hF, 7'h7F);
        waitTo(5);  checkDisplay("d1", 4'b1101, 7'h30);
        waitTo(10); checkDisplay("d2", 4'b1011, 7'h24);
        waitTo(15); checkDisplay("d3", 4'b0111, 7'h79);
        waitTo(20); checkOutput("tick_on", 32'(frame_tick), 32'd1);
        checkDisplay("f1d0", 4'b1110, 7'h19);
        waitTo(21); checkOutput("tick_off", 32'(frame_tick), 32'd0);

        // Mid-frame VALUE write must not disturb the current frame
        waitTo(26);
        applyStimulus(1'b1, 2'd0, 16'h8888, 2'd0);
        waitTo(30); checkDisplay("old_d2", 4'b1011, 7'h24);
        waitTo(35); checkDisplay("old_d3", 4'b0111, 7'h79);
        waitTo(40); checkDisplay("new_d0", 4'b1110, 7'h00);
        waitTo(45); checkDisplay("new_d1", 4'b1101, 7'h00);

        // Digit and dp masks, then frame counter wrap
        applyStimulus(1'b1, 2'd1, 16'h0A31, 2'd0);
        waitTo(60); checkOutput("msk_d0_an", 32'(anode), 32'hF);
        checkOutput("msk_d0_dp", 32'(decimal_point), 32'd1);
        waitTo(65); checkOutput("msk_d1_an", 32'(anode), 32'hD);
        checkOutput("msk_d1_dp", 32'(decimal_point), 32'd0);
        waitTo(70); checkOutput("msk_d2_an", 32'(anode), 32'hF);
        waitTo(75); checkOutput("msk_d3_an", 32'(anode), 32'h7);
        checkOutput("msk_d3_dp", 32'(decimal_point), 32'd1);
        waitTo(5119);
        applyStimulus(1'b0, 2'd0, 16'h0000, 2'd2);
        checkOutput("status_ff", 32'(bus.rd_data), 32'hFF07);
        @(negedge clk);
        checkOutput("status_wrap", 32'(bus.rd_data), 32'h0004);

        // Disable during digit 2 drive, then re-enable with a new value
        waitTo(5150);
        applyStimulus(1'b1, 2'd1, 16'h0A30, 2'd2);
        checkDisplay("dis", 4'hF, 7'h7F);
        checkOutput("dis_rd_before", 32'(bus.rd_data), 32'h0106);
        @(negedge clk);
        checkOutput("dis_status", 32'(bus.rd_data), 32'h0100);
        applyStimulus(1'b1, 2'd0, 16'hABCD, 2'd0);
        applyStimulus(1'b1, 2'd1, 16'h0F01, 2'd0);
        c0 = cyc;
        checkDisplay("ren_d0", 4'b1110, 7'h21);
        waitTo(5);  checkDisplay("ren_d1", 4'b1101, 7'h46);

        // Register readback
        applyStimulus(1'b0, 2'd0, 16'h0000, 2'd0);
        checkOutput("rd_value", 32'(bus.rd_data), 32'hABCD);
        applyStimulus(1'b0, 2'd0, 16'h0000, 2'd1);
        checkOutput("rd_ctrl", 32'(bus.rd_data), 32'h0F01);
        applyStimulus(1'b0, 2'd0, 16'h0000, 2'd3);
        checkOutput("rd_addr3", 32'(bus.rd_data), 32'h0000);
        applyStimulus(1'b1, 2'd1, 16'hFFFF, 2'd1);
        checkOutput("rd_same_edge", 32'(bus.rd_data), 32'h0F01);
        applyStimulus(1'b0, 2'd0, 16'h0000, 2'd1);
        checkOutput("rd_ctrl_mask", 32'(bus.rd_data), 32'h0FF1);

        // Short asynchronous reset pulse between clock edges
        @(negedge clk);
        #2 reset_n = 1'b0;
        #0.5;
        checkDisplay("arst", 4'hF, 7'h7F);
        checkOutput("arst_dp", 32'(decimal_point), 32'd1);
        checkOutput("arst_rd", 32'(bus.rd_data), 32'd0);
        #0.5 reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 2'd0, 16'h0000, 2'd0);
        checkOutput("arst_value", 32'(bus.rd_data), 32'h0000);
        applyStimulus(1'b0, 2'd0, 16'h0000, 2'd1);
        checkOutput("arst_ctrl", 32'(bus.rd_data), 32'h0000);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
